// File: rtl/lcd_responder.sv
// Panel-side model of an HD44780-class character LCD: decodes E/RS/RW/D bus cycles
// at the fall of E, holds an 80-byte DDRAM, the address counter and the busy flag.
module lcd_responder #(
  parameter int unsigned ADDRW       = 7,
  parameter int unsigned DEPTH       = 80,
  parameter int unsigned BUSY_CYCLES = 4,
  parameter int unsigned HOME_CYCLES = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_E,
  input  logic             i_RS,
  input  logic             i_RW,
  input  logic [7:0]       i_data,
  output logic [7:0]       o_data,
  output logic             o_busy,
  output logic             o_viol,
  output logic             o_disp_on,
  input  logic [ADDRW-1:0] i_dbg_addr,
  output logic [7:0]       o_dbg_char
);

  localparam int unsigned CNTW =
    $clog2(((HOME_CYCLES > BUSY_CYCLES) ? HOME_CYCLES : BUSY_CYCLES) + 1);
  localparam logic [ADDRW-1:0] LAST = ADDRW'(DEPTH - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_CLEAR} state_t;

  state_t           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [ADDRW-1:0] ptr_q, ptr_d;
  logic [ADDRW-1:0] ac_q, ac_d;
  logic             id_q, id_d, s_q, s_d;
  logic             disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
  logic             dl_q, dl_d, n_q, n_d, f_q, f_d;
  logic             e_q, rs_l_q, rs_l_d, rw_l_q, rw_l_d;
  logic [7:0]       d_l_q, d_l_d;
  logic             busy_q, busy_d, viol_q, viol_d;

  logic [7:0]       mem [DEPTH];
  logic             mem_we;
  logic [ADDRW-1:0] mem_addr;
  logic [7:0]       mem_wdata;

  logic             fall, stat_rd;
  logic [ADDRW-1:0] ac_inc, ac_dec, ac_step, ac_set;
  logic             unused_mode;

  assign fall    = e_q & ~i_E;
  assign stat_rd = ~rs_l_q & rw_l_q;
  assign ac_inc  = (ac_q == LAST) ? '0 : ac_q + ADDRW'(1);
  assign ac_dec  = (ac_q == '0) ? LAST : ac_q - ADDRW'(1);
  assign ac_step = id_q ? ac_inc : ac_dec;
  assign ac_set  = ADDRW'(d_l_q[6:0]);

  // S, C, B, DL, N and F are held for completeness but never steer behaviour
  assign unused_mode = ^{s_q, cur_q, blink_q, dl_q, n_q, f_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    ac_d      = ac_q;
    id_d      = id_q;
    s_d       = s_q;
    disp_d    = disp_q;
    cur_d     = cur_q;
    blink_d   = blink_q;
    dl_d      = dl_q;
    n_d       = n_q;
    f_d       = f_q;
    rs_l_d    = rs_l_q;
    rw_l_d    = rw_l_q;
    d_l_d     = d_l_q;
    viol_d    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = ac_q;
    mem_wdata = d_l_q;

    if (i_E) begin
      rs_l_d = i_RS;
      rw_l_d = i_RW;
      d_l_d  = i_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (fall && !stat_rd) begin
          state_d = ST_BUSY;
          cnt_d   = CNTW'(BUSY_CYCLES);
          if (rs_l_q) begin
            mem_we = ~rw_l_q;
            ac_d   = ac_step;
          end else begin
            casez (d_l_q)
              8'b1???????: ac_d = (ac_set > LAST) ? LAST : ac_set;
              8'b01??????: ;
              8'b001?????: {dl_d, n_d, f_d} = d_l_q[4:2];
              8'b0001????: if (!d_l_q[3]) ac_d = d_l_q[2] ? ac_inc : ac_dec;
              8'b00001???: {disp_d, cur_d, blink_d} = d_l_q[2:0];
              8'b000001??: {id_d, s_d} = d_l_q[1:0];
              8'b0000001?: begin
                ac_d  = '0;
                cnt_d = CNTW'(HOME_CYCLES);
              end
              8'b00000001: begin
                ac_d    = '0;
                id_d    = 1'b1;
                ptr_d   = '0;
                state_d = ST_CLEAR;
              end
              default: ;
            endcase
          end
        end
      end
      ST_BUSY: begin
        cnt_d  = cnt_q - CNTW'(1);
        viol_d = fall & ~stat_rd;
        if (cnt_q == CNTW'(1)) state_d = ST_IDLE;
      end
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = ptr_q;
        mem_wdata = 8'h20;
        ptr_d     = ptr_q + ADDRW'(1);
        viol_d    = fall & ~stat_rd;
        if (ptr_q == LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      ac_q    <= '0;
      id_q    <= 1'b1;
      s_q     <= 1'b0;
      disp_q  <= 1'b0;
      cur_q   <= 1'b0;
      blink_q <= 1'b0;
      dl_q    <= 1'b0;
      n_q     <= 1'b0;
      f_q     <= 1'b0;
      e_q     <= 1'b0;
      rs_l_q  <= 1'b0;
      rw_l_q  <= 1'b0;
      d_l_q   <= 8'h00;
      busy_q  <= 1'b0;
      viol_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      ac_q    <= ac_d;
      id_q    <= id_d;
      s_q     <= s_d;
      disp_q  <= disp_d;
      cur_q   <= cur_d;
      blink_q <= blink_d;
      dl_q    <= dl_d;
      n_q     <= n_d;
      f_q     <= f_d;
      e_q     <= i_E;
      rs_l_q  <= rs_l_d;
      rw_l_q  <= rw_l_d;
      d_l_q   <= d_l_d;
      busy_q  <= busy_d;
      viol_q  <= viol_d;
    end
  end

  // DDRAM contents survive reset
  always_ff @(posedge i_clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_comb begin
    o_data = 8'h00;
    if (i_E && i_RW) o_data = i_RS ? mem[ac_q] : 8'({busy_q, ac_q});
  end

  assign o_dbg_char = (i_dbg_addr <= LAST) ? mem[i_dbg_addr] : 8'h00;
  assign o_busy     = busy_q;
  assign o_viol     = viol_q;
  assign o_disp_on  = disp_q;

endmodule

// File: tb/tb_lcd_responder.sv
// Scoreboard bench for lcd_responder: stimulus queues expectations, a monitor
// checks read data, busy lengths, violation pulses and debug probes.
module tb_lcd_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       e = 1'b0, rs = 1'b0, rw = 1'b0;
  logic [7:0] din = 8'h00;
  logic [6:0] dbg_addr = 7'd0;
  logic [7:0] o_data, o_dbg_char;
  logic       o_busy, o_viol, o_disp_on;

  lcd_responder dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_E        (e),
    .i_RS       (rs),
    .i_RW       (rw),
    .i_data     (din),
    .o_data     (o_data),
    .o_busy     (o_busy),
    .o_viol     (o_viol),
    .o_disp_on  (o_disp_on),
    .i_dbg_addr (dbg_addr),
    .o_dbg_char (o_dbg_char)
  );

  initial forever #5 clk = ~clk;

  typedef struct { logic [7:0] exp; logic [95:0] nm; } dexp_t;
  typedef struct { int kind; logic [7:0] exp; logic [95:0] nm; } pexp_t;

  dexp_t dq[$];
  pexp_t pq[$];
  int    bq[$];
  int    vq[$];
  int    total = 0, bad = 0;
  int    n_to = 0, seen_to = 0;
  bit    probe_req = 1'b0, done = 1'b0;

  task automatic bus(input logic r, input logic w, input logic [7:0] d);
    @(posedge clk); #1;
    e = 1'b1; rs = r; rw = w; din = d;
    @(posedge clk); #1;
    e = 1'b0; din = 8'h00;
  endtask

  task automatic wait_idle();
    @(posedge clk); #1;
    for (int i = 0; i < 200 && o_busy; i++) begin
      @(posedge clk); #1;
    end
    if (o_busy) n_to++;
  endtask

  task automatic ins(input logic [7:0] d, input int blen);
    bq.push_back(blen);
    bus(1'b0, 1'b0, d);
    wait_idle();
  endtask

  task automatic wdat(input logic [7:0] d);
    bq.push_back(4);
    bus(1'b1, 1'b0, d);
    wait_idle();
  endtask

  task automatic stat(input logic [7:0] exp, input logic [95:0] nm);
    dexp_t t;
    t.exp = exp; t.nm = nm;
    dq.push_back(t);
    bus(1'b0, 1'b1, 8'h00);
  endtask

  task automatic rdat(input logic [7:0] exp, input logic [95:0] nm);
    dexp_t t;
    t.exp = exp; t.nm = nm;
    dq.push_back(t);
    bq.push_back(4);
    bus(1'b1, 1'b1, 8'h00);
    wait_idle();
  endtask

  // kind 0: DDRAM via debug port, 1: busy flag, 2: display-on
  task automatic probe(input int kind, input logic [6:0] a, input logic [7:0] exp,
                       input logic [95:0] nm);
    pexp_t t;
    t.kind = kind; t.exp = exp; t.nm = nm;
    pq.push_back(t);
    dbg_addr  = a;
    probe_req = 1'b1;
    @(posedge clk); #1;
    probe_req = 1'b0;
  endtask

  initial begin
    int         run;
    dexp_t      d;
    pexp_t      p;
    int         b;
    logic [7:0] act;
    run = 0;
    forever begin
      @(negedge clk);
      if (n_to != seen_to) begin
        total++; bad++;
        $display("FAIL busy_timeout: busy still high after 200 cycles (count %0d, required %0d)",
                 n_to, seen_to);
        seen_to = n_to;
      end
      if (e && rw) begin
        total++;
        if (dq.size() == 0) begin
          bad++;
          $display("FAIL read_unexpected: o_data=%h with no expectation queued", o_data);
        end else begin
          d = dq.pop_front();
          if (o_data !== d.exp) begin
            bad++;
            $display("FAIL %s: o_data=%h required %h", d.nm, o_data, d.exp);
          end
        end
      end
      if (o_viol) begin
        total++;
        if (vq.size() == 0) begin
          bad++;
          $display("FAIL viol_unexpected: o_viol=1 required 0");
        end else begin
          void'(vq.pop_front());
        end
      end
      if (!rst_n) begin
        run = 0;
      end else if (o_busy) begin
        run++;
      end else if (run > 0) begin
        total++;
        if (bq.size() == 0) begin
          bad++;
          $display("FAIL busy_unexpected: busy ran %0d cycles with none queued", run);
        end else begin
          b = bq.pop_front();
          if (run != b) begin
            bad++;
            $display("FAIL busy_len: busy ran %0d cycles required %0d", run, b);
          end
        end
        run = 0;
      end
      if (probe_req) begin
        total++;
        p = pq.pop_front();
        act = (p.kind == 0) ? o_dbg_char :
              (p.kind == 1) ? {7'd0, o_busy} : {7'd0, o_disp_on};
        if (act !== p.exp) begin
          bad++;
          $display("FAIL %s: got %h required %h", p.nm, act, p.exp);
        end
      end
      if (done) begin
        total += dq.size() + bq.size() + vq.size();
        bad   += dq.size() + bq.size() + vq.size();
        if (dq.size() + bq.size() + vq.size() != 0)
          $display("FAIL leftover: reads=%0d busy=%0d viol=%0d still expected, required 0",
                   dq.size(), bq.size(), vq.size());
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    probe(1, 7'd0, 8'h00, "busy_rst");
    probe(2, 7'd0, 8'h00, "disp_rst");
    stat(8'h00, "stat_rst");

    ins(8'h85, 4);
    stat(8'h05, "ac_5");

    ins(8'h01, 80);
    probe(0, 7'd0,  8'h20, "clr_0");
    probe(0, 7'd40, 8'h20, "clr_40");
    probe(0, 7'd79, 8'h20, "clr_79");
    stat(8'h00, "ac_clr");

    ins(8'hCF, 4);
    wdat(8'h41);
    probe(0, 7'd79, 8'h41, "ddram_79");
    stat(8'h00, "ac_wrap_up");
    ins(8'h04, 4);
    wdat(8'h42);
    probe(0, 7'd0, 8'h42, "ddram_0");
    stat(8'h4F, "ac_wrap_dn");
    ins(8'hFF, 4);
    stat(8'h4F, "ac_clamp");
    ins(8'h06, 4);

    // AC=79, I/D=1: accepted write, then a write and a status read while busy
    bq.push_back(4);
    bus(1'b1, 1'b0, 8'h55);
    vq.push_back(1);
    bus(1'b1, 1'b0, 8'h66);
    stat(8'h80, "stat_busy");
    wait_idle();
    probe(0, 7'd79, 8'h55, "wr_before");
    probe(0, 7'd0,  8'h42, "wr_dropped");
    stat(8'h00, "ac_after_v");

    ins(8'h0C, 4);
    probe(2, 7'd0, 8'h01, "disp_on");
    ins(8'h83, 4);
    wdat(8'h5A);
    ins(8'h83, 4);
    rdat(8'h5A, "rd_5a");
    stat(8'h04, "ac_rd");

    ins(8'h10, 4);
    stat(8'h03, "shift_l");
    ins(8'h14, 4);
    stat(8'h04, "shift_r");
    ins(8'h18, 4);
    stat(8'h04, "shift_disp");
    ins(8'h02, 32);
    stat(8'h00, "ac_home");

    ins(8'h82, 4);
    wdat(8'h66);
    ins(8'h94, 4);
    wdat(8'h77);
    probe(0, 7'd20, 8'h77, "pre_20");
    // clear, then reset once ptr reaches 10
    bus(1'b0, 1'b0, 8'h01);
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    probe(1, 7'd0,  8'h00, "busy_abort");
    probe(0, 7'd2,  8'h20, "part_clr_2");
    probe(0, 7'd20, 8'h77, "kept_20");
    probe(2, 7'd0,  8'h00, "disp_rst2");
    stat(8'h00, "stat_rst2");

    repeat (3) @(posedge clk);
    #1 done = 1'b1;
  end

endmodule
